sa_sched: RTL
=============

Name: sa_sched

Overview:
- Sequencer for one systolic array of sa_cell instances, ROWS x COLS.
- Accepts a job (reduction depth K, optional weight preload) through a valid/ready handshake.
- Broadcasts the per-phase ctrl code to every cell and generates skewed feed enables for the left (row) and top (column) edge injectors.
- Paces result drain through the move-buffer chain under downstream backpressure; sits between the job dispatcher and the array wrapper.

Parameters:
- ROWS, 4, array rows; also the move-chain drain length in beats.
- COLS, 4, array columns.
- CTRL_WIDTH, 3, width of the ctrl code driven to cells.
- K_WIDTH, 8, width of the reduction depth field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  scheduler can accept a job
- job_k  in  K_WIDTH  reduction depth, sampled on handshake
- job_load  in  1  1 = run LOAD phase first, sampled on handshake
- ctrl  out  CTRL_WIDTH  ctrl code broadcast to all cells
- row_feed_en  out  ROWS  bit r enables the left-edge injector of row r
- col_feed_en  out  COLS  bit c enables the top-edge injector of column c
- move_shift  out  1  advance the move-buffer chain one position
- out_valid  out  1  drain beat present on the move-buffer output
- out_last  out  1  final drain beat of the job
- out_ready  in  1  downstream accepts the drain beat
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the job completes

Behaviour:
- Ctrl encoding (package constants): NOP=0, CLEAR=1, LOAD=2, COMPUTE=3, DRAIN=4. Values 5–7 are reserved and never driven.
- All outputs are registered.
- Reset values: ctrl=NOP, job_ready=1, all feed enables=0, move_shift=0, out_valid=0, out_last=0, busy=0, done=0.
- FSM states: IDLE, CLEAR, LOAD, COMPUTE, DRAIN, DONE. A single phase counter cnt (width clog2(max(K_max+ROWS+COLS, ROWS))+1) is cleared on every state entry.
- IDLE: job_ready=1, busy=0.
  - Handshake (job_valid & job_ready) latches job_k/job_load and goes to CLEAR next cycle; job_ready drops the same edge.
  - If job_k==0, go directly to DONE (no CLEAR/LOAD/COMPUTE/DRAIN).
- CLEAR: exactly 1 cycle, ctrl=CLEAR. Then LOAD if load flag set, else COMPUTE.
- LOAD: ctrl=LOAD, move_shift=1, for exactly ROWS cycles, then COMPUTE.
- COMPUTE: ctrl=COMPUTE for exactly K+ROWS+COLS-2 cycles (cnt = 0..last).
  - row_feed_en[r]=1 iff r <= cnt <= r+K-1.
  - col_feed_en[c]=1 iff c <= cnt <= c+K-1.
  - Enables are registered so they align with ctrl on the same cycle.
  - Then DRAIN.
- DRAIN: ctrl=DRAIN, out_valid=1.
  - move_shift = out_valid & out_ready; the beat counter advances only on that handshake.
  - out_last=1 on beat ROWS-1.
  - out_ready low: ctrl stays DRAIN, move_shift=0, no counter change. out_valid must not drop while stalled.
  - Handshake on the last beat goes to DONE.
- DONE: done=1 for one cycle, ctrl=NOP, busy=0, then IDLE with job_ready=1 the following cycle. No back-to-back acceptance in the DONE cycle.
- busy=1 in all states except IDLE.
- job_valid while busy is ignored; the request is held by the requester.
- Width rules: K+ROWS+COLS-2 is computed in counter width with no overflow.
  - Max K = 2^K_WIDTH-1.
  - Enable comparisons are unsigned and use that width.
- Reset mid-job returns to IDLE/reset values on the next edge. No done pulse; the partial job is discarded.

Decomposition:
- Package sa_pkg holds:
  - ctrl code localparams NOP/CLEAR/LOAD/COMPUTE/DRAIN;
  - the FSM state enum;
  - a clog2-based counter width helper.
- One sub-module, sa_skew_gen: parameterized by lane count N. Inputs cnt, K, enable. Outputs N registered feed enables. Instanced twice, once for rows (N=ROWS) and once for columns (N=COLS).

Test Plan:
- Reset, then idle 5 cycles -> ctrl=0, job_ready=1, busy=0, all enables 0, done never asserted.
- Job K=3, load=1, ROWS=COLS=4, out_ready=1:
  - CLEAR 1 cycle, then LOAD 4 cycles with move_shift=1.
  - COMPUTE 9 cycles; row_feed_en[2] high on compute cycles 2–4 only; col_feed_en[3] high on cycles 3–5.
  - DRAIN 4 beats, out_last on beat 4, done pulse exactly once.
- Job K=2, load=0, out_ready toggling 1,0,0,1,…:
  - LOAD skipped.
  - During DRAIN, move_shift equals out_ready cycle by cycle.
  - Exactly 4 accepted beats, out_valid held high through stalls.
- job_k=0 -> goes to DONE the cycle after the handshake with ctrl staying NOP; no feed enable or move_shift ever high; done pulses once.
- rst asserted on COMPUTE cycle 3 of a K=5 job -> next edge all outputs at reset values; new job then completes normally.
- job_valid held high through a whole K=1 job -> second job accepted only after the done cycle. Only two handshakes occur over two job lengths.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array sequencer: cell ctrl codes, FSM states and
// the phase-counter width helper.
package sa_pkg;

    localparam logic [2:0] CTRL_NOP     = 3'd0;
    localparam logic [2:0] CTRL_CLEAR   = 3'd1;
    localparam logic [2:0] CTRL_LOAD    = 3'd2;
    localparam logic [2:0] CTRL_COMPUTE = 3'd3;
    localparam logic [2:0] CTRL_DRAIN   = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StCompute,
        StDrain,
        StDone
    } sa_state_e;

    // Wide enough for K_max+ROWS+COLS (longest compute span) and the drain beat count.
    function automatic int unsigned sa_cnt_width(input int unsigned k_width,
                                                 input int unsigned rows,
                                                 input int unsigned cols);
        int unsigned k_max;
        int unsigned span;
        k_max = (32'd1 << k_width) - 32'd1;
        span  = k_max + rows + cols;
        if (rows > span) begin
            span = rows;
        end
        return $clog2(span) + 1;
    endfunction

endpackage

// File: rtl/sa_skew_gen.sv
// Skewed edge-injector enables: lane i is active while i <= cnt <= i+K-1.
// Registered so the enables line up with the broadcast ctrl code.
module sa_skew_gen #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 10,
    parameter int unsigned K_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic [K_W-1:0]   k,
    input  logic             enable,
    output logic [N-1:0]     feed_en
);

    logic [N-1:0] feed_en_d;
    logic [N-1:0] feed_en_q;

    always_comb begin
        logic [CNT_W-1:0] lo;
        logic [CNT_W-1:0] hi;
        feed_en_d = '0;
        for (int i = 0; i < int'(N); i++) begin
            lo           = CNT_W'(i);
            hi           = lo + CNT_W'(k);
            feed_en_d[i] = enable && (cnt >= lo) && (cnt < hi);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feed_en_q <= '0;
        end else begin
            feed_en_q <= feed_en_d;
        end
    end

    assign feed_en = feed_en_q;

endmodule

// File: rtl/sa_sched.sv
// Job sequencer for one ROWS x COLS systolic array: CLEAR, optional LOAD, skewed COMPUTE,
// then a backpressured DRAIN of ROWS beats through the move-buffer chain.
module sa_sched
    import sa_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned CTRL_WIDTH = 3,
    parameter int unsigned K_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [K_WIDTH-1:0]    job_k,
    input  logic                  job_load,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [ROWS-1:0]       row_feed_en,
    output logic [COLS-1:0]       col_feed_en,
    output logic                  move_shift,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CntW = sa_cnt_width(K_WIDTH, ROWS, COLS);
    localparam logic [CntW-1:0] LastBeat = CntW'(ROWS - 1);

    sa_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CntW-1:0]       compute_last;
    logic [K_WIDTH-1:0]    k_q, k_d;
    logic                  load_q, load_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                  job_ready_q, job_ready_d;
    logic                  load_shift_q, load_shift_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  beat_ack;
    logic                  compute_en;

    // K >= 1 whenever COMPUTE runs, so K+ROWS+COLS-3 never wraps.
    assign compute_last = CntW'(k_q) + CntW'(ROWS + COLS) - CntW'(3);
    assign beat_ack     = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        load_d  = load_q;
        unique case (state_q)
            StIdle: begin
                if (job_valid && job_ready_q) begin
                    k_d     = job_k;
                    load_d  = job_load;
                    cnt_d   = '0;
                    state_d = (job_k == '0) ? StDone : StClear;
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = load_q ? StLoad : StCompute;
            end
            StLoad: begin
                if (cnt_q == LastBeat) begin
                    cnt_d   = '0;
                    state_d = StCompute;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCompute: begin
                if (cnt_q == compute_last) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (beat_ack) begin
                    if (cnt_q == LastBeat) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in the same cycle as the state.
    always_comb begin
        ctrl_d       = CTRL_WIDTH'(CTRL_NOP);
        job_ready_d  = 1'b0;
        load_shift_d = 1'b0;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        unique case (state_d)
            StIdle: begin
                job_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            StClear: ctrl_d = CTRL_WIDTH'(CTRL_CLEAR);
            StLoad: begin
                ctrl_d       = CTRL_WIDTH'(CTRL_LOAD);
                load_shift_d = 1'b1;
            end
            StCompute: ctrl_d = CTRL_WIDTH'(CTRL_COMPUTE);
            StDrain: begin
                ctrl_d      = CTRL_WIDTH'(CTRL_DRAIN);
                out_valid_d = 1'b1;
                out_last_d  = (cnt_d == LastBeat);
            end
            StDone: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            k_q          <= '0;
            load_q       <= 1'b0;
            ctrl_q       <= CTRL_WIDTH'(CTRL_NOP);
            job_ready_q  <= 1'b1;
            load_shift_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            load_q       <= load_d;
            ctrl_q       <= ctrl_d;
            job_ready_q  <= job_ready_d;
            load_shift_q <= load_shift_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign compute_en = (state_d == StCompute);

    sa_skew_gen #(
        .N     (ROWS),
        .CNT_W (CntW),
        .K_W   (K_WIDTH)
    ) u_row_skew (
        .clk     (clk),
        .rst     (rst),
        .cnt     (cnt_d),
        .k       (k_q),
        .enable  (compute_en),
        .feed_en (row_feed_en)
    );

    sa_skew_gen #(
        .N     (COLS),
        .CNT_W (CntW),
        .K_W   (K_WIDTH)
    ) u_col_skew (
        .clk     (clk),
        .rst     (rst),
        .cnt     (cnt_d),
        .k       (k_q),
        .enable  (compute_en),
        .feed_en (col_feed_en)
    );

    assign ctrl       = ctrl_q;
    assign job_ready  = job_ready_q;
    // The drain handshake must follow out_ready in the same cycle to avoid losing a beat.
    assign move_shift = load_shift_q | beat_ack;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
